// File: rtl/ysyx_23060208_rd_arbiter.sv
// Two-master (IFU = m0, LSU = m1) read-channel arbiter sharing one slave.
// Only one read is outstanding at a time; ties are broken round-robin.
module ysyx_23060208_rd_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,

  input  logic [DATA_WIDTH-1:0] m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,

  output logic [DATA_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,

  output logic [1:0]            grant_o,
  output logic [1:0]            state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both 1; a master holds valid and payload stable until it does.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  last_q, last_d;    // 1 = LSU granted most recently
  logic                  owner_q, owner_d;  // 1 = LSU owns the transaction
  logic [DATA_WIDTH-1:0] addr_q, addr_d;

  logic in_idle, in_addr, in_data;
  logic win1, ar_fire, r_fire;

  // Decodes are qualified with rst so every output is 0 while reset is held.
  assign in_idle = rst && (state_q == IDLE);
  assign in_addr = rst && (state_q == ADDR);
  assign in_data = rst && (state_q == DATA);

  assign win1    = m1_arvalid && (!m0_arvalid || !last_q);
  assign ar_fire = in_idle && (m0_arvalid || m1_arvalid);
  assign r_fire  = s_rvalid && s_rready;

  assign m0_arready = ar_fire && !win1;
  assign m1_arready = ar_fire && win1;

  assign s_arvalid = in_addr;
  assign s_araddr  = in_addr ? addr_q : '0;
  assign s_rready  = in_data && (owner_q ? m1_rready : m0_rready);

  assign m0_rvalid = in_data && !owner_q && s_rvalid;
  assign m0_rdata  = (in_data && !owner_q) ? s_rdata : '0;
  assign m0_rresp  = (in_data && !owner_q) ? s_rresp : 2'b00;
  assign m1_rvalid = in_data && owner_q && s_rvalid;
  assign m1_rdata  = (in_data && owner_q) ? s_rdata : '0;
  assign m1_rresp  = (in_data && owner_q) ? s_rresp : 2'b00;

  assign grant_o = (in_addr || in_data) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (ar_fire) begin
          state_d = ADDR;
          last_d  = win1;
          owner_d = win1;
          addr_d  = win1 ? m1_araddr : m0_araddr;
        end
      end
      ADDR: begin
        if (s_arready) state_d = DATA;
      end
      DATA: begin
        if (r_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to LSU so the IFU wins the first tie after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// Bench for the two-master read arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model and a read-data scoreboard.
module tb_ysyx_23060208_rd_arbiter;

  localparam int W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic         clk;
  logic         rst;
  logic [W-1:0] m0_araddr, m1_araddr, s_araddr;
  logic         m0_arvalid, m1_arvalid, s_arvalid;
  logic         m0_arready, m1_arready, s_arready;
  logic [W-1:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0]   m0_rresp, m1_rresp, s_rresp;
  logic         m0_rvalid, m1_rvalid, s_rvalid;
  logic         m0_rready, m1_rready, s_rready;
  logic [1:0]   grant_o, state_o;

  int n_pass;
  int n_total;
  int mdl_last;               // model: master granted most recently (0 IFU, 1 LSU)
  logic [W-1:0] exp_q[$];

  logic [3*W+13:0] all_out;
  assign all_out = {m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
                    m0_rresp, m1_rresp, s_arvalid, s_araddr, s_rready, grant_o, state_o};

  ysyx_23060208_rd_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant_o(grant_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
    m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
    s_arready = 0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 0;
    clear_inputs();
    @(negedge clk);
    rst = 1;
    mdl_last = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    m0_arvalid = 1; m1_arvalid = 1; m0_araddr = 32'h1111_1111; m1_araddr = 32'h2222_2222;
    s_arready = 1; s_rvalid = 1; s_rdata = '1; s_rresp = 2'b11; m0_rready = 1; m1_rready = 1;
    @(negedge clk); #1;
    n_total++;
    if (all_out !== '0) $display("FAIL reset_outputs got=%h exp=0", all_out);
    else n_pass++;
    clear_inputs();
    @(negedge clk);
    rst = 1; mdl_last = 1;
    #1;
    n_total++;
    if (all_out !== '0) $display("FAIL reset_release_idle got=%h exp=0", all_out);
    else n_pass++;
  endtask

  task automatic test_single();
    @(negedge clk);
    m0_araddr = 32'h8000_0000; m0_arvalid = 1;
    #1;
    n_total++;
    if ({m0_arready, m1_arready, grant_o} !== 4'b1000)
      $display("FAIL single_ar_accept got=%b exp=1000", {m0_arready, m1_arready, grant_o});
    else n_pass++;
    @(negedge clk);
    m0_arvalid = 0;
    #1;
    n_total++;
    if ({s_arvalid, s_araddr, grant_o, m0_arready} !== {1'b1, 32'h8000_0000, 2'b01, 1'b0})
      $display("FAIL single_addr_phase got=%h exp=%h", {s_arvalid, s_araddr, grant_o, m0_arready},
               {1'b1, 32'h8000_0000, 2'b01, 1'b0});
    else n_pass++;
    s_arready = 1;
    @(negedge clk);
    s_arready = 0; s_rvalid = 1; s_rdata = 32'h1234_5678; s_rresp = 2'b00; m0_rready = 1;
    #1;
    n_total++;
    if ({m0_rvalid, m0_rdata, s_rready, grant_o, state_o} !== {1'b1, 32'h1234_5678, 1'b1, 2'b01, ST_DATA})
      $display("FAIL single_data_phase got=%h exp=%h", {m0_rvalid, m0_rdata, s_rready, grant_o, state_o},
               {1'b1, 32'h1234_5678, 1'b1, 2'b01, ST_DATA});
    else n_pass++;
    @(negedge clk);
    s_rvalid = 0; m0_rready = 0;
    #1;
    n_total++;
    if ({grant_o, state_o, s_arvalid, s_rready} !== 6'b0)
      $display("FAIL single_back_idle got=%b exp=000000", {grant_o, state_o, s_arvalid, s_rready});
    else n_pass++;
    mdl_last = 0;
  endtask

  task automatic test_round_robin();
    int exp_w;
    apply_reset();
    m0_araddr = 32'h8000_1000; m1_araddr = 32'h0000_4000;
    m0_arvalid = 1; m1_arvalid = 1;
    for (int k = 0; k < 4; k++) begin
      exp_w = (k % 2 == 0) ? 0 : 1;
      #1;
      n_total++;
      if ({m0_arready, m1_arready} !== ((exp_w == 1) ? 2'b01 : 2'b10))
        $display("FAIL rr_grant k=%0d got=%b exp_winner=%0d", k, {m0_arready, m1_arready}, exp_w);
      else n_pass++;
      @(negedge clk);
      s_arready = 1;
      #1;
      n_total++;
      if ({s_araddr, grant_o} !== {((exp_w == 1) ? 32'h0000_4000 : 32'h8000_1000),
                                   ((exp_w == 1) ? 2'b10 : 2'b01)})
        $display("FAIL rr_addr k=%0d got=%h grant=%b", k, s_araddr, grant_o);
      else n_pass++;
      @(negedge clk);
      s_arready = 0; s_rvalid = 1; m0_rready = 1; m1_rready = 1;
      @(negedge clk);
      s_rvalid = 0;
    end
    m0_arvalid = 0; m1_arvalid = 0; m0_rready = 0; m1_rready = 0;
    mdl_last = 1;
  endtask

  task automatic test_addr_stall();
    m1_araddr = 32'h0000_2000; m1_arvalid = 1;
    #1;
    n_total++;
    if ({m0_arready, m1_arready} !== 2'b01)
      $display("FAIL stall_lsu_accept got=%b exp=01", {m0_arready, m1_arready});
    else n_pass++;
    @(negedge clk);
    m1_arvalid = 0; m0_araddr = 32'h8000_0100; m0_arvalid = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if ({s_arvalid, s_araddr, m0_arready, m1_arready, grant_o} !== {1'b1, 32'h0000_2000, 2'b00, 2'b10})
        $display("FAIL stall_hold i=%0d got=%h exp=%h", i, {s_arvalid, s_araddr, m0_arready, m1_arready, grant_o},
                 {1'b1, 32'h0000_2000, 2'b00, 2'b10});
      else n_pass++;
      @(negedge clk);
    end
    s_arready = 1;
    @(negedge clk);
    s_arready = 0;
    mdl_last = 1;
  endtask

  task automatic test_rdata_backpressure();
    s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b10; m1_rready = 0; m0_rready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if ({m1_rvalid, m1_rdata, m1_rresp, m0_rvalid, s_rready, state_o, m0_arready} !==
          {1'b1, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, ST_DATA, 1'b0})
        $display("FAIL bp_hold i=%0d got=%h exp=%h", i,
                 {m1_rvalid, m1_rdata, m1_rresp, m0_rvalid, s_rready, state_o, m0_arready},
                 {1'b1, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, ST_DATA, 1'b0});
      else n_pass++;
      @(negedge clk);
    end
    m1_rready = 1;
    #1;
    n_total++;
    if ({m1_rvalid, s_rready, m0_rvalid} !== 3'b110)
      $display("FAIL bp_release got=%b exp=110", {m1_rvalid, s_rready, m0_rvalid});
    else n_pass++;
    @(negedge clk);
    s_rvalid = 0; m1_rready = 0; m0_rready = 0;
  endtask

  task automatic test_back_to_back();
    #1;
    n_total++;
    if ({m0_arready, m1_arready, state_o, grant_o} !== {2'b10, ST_IDLE, 2'b00})
      $display("FAIL b2b_grant got=%b exp=100000", {m0_arready, m1_arready, state_o, grant_o});
    else n_pass++;
    @(negedge clk);
    m0_arvalid = 0;
    mdl_last = 0;
  endtask

  task automatic test_rvalid_ignored();
    for (int i = 0; i < 2; i++) begin
      s_rvalid = 1; s_rdata = $urandom; m0_rready = 1; m1_rready = 1;
      #1;
      n_total++;
      if ({s_rready, m0_rvalid, m1_rvalid, m0_rdata, state_o, s_arvalid, s_araddr} !==
          {3'b000, 32'h0, ST_ADDR, 1'b1, 32'h8000_0100})
        $display("FAIL ignore_rvalid i=%0d got=%h", i,
                 {s_rready, m0_rvalid, m1_rvalid, m0_rdata, state_o, s_arvalid, s_araddr});
      else n_pass++;
      @(negedge clk);
    end
    s_rvalid = 0; m0_rready = 0; m1_rready = 0;
  endtask

  task automatic test_reset_mid_data();
    s_arready = 1;
    @(negedge clk);
    s_arready = 0;
    m0_araddr = 32'h8000_0200; m0_arvalid = 1;
    s_rvalid = 1; s_rdata = 32'h0000_0055; m0_rready = 0;
    #1;
    n_total++;
    if ({m0_rvalid, state_o, m0_arready} !== {1'b1, ST_DATA, 1'b0})
      $display("FAIL midrst_pre got=%b exp=1100", {m0_rvalid, state_o, m0_arready});
    else n_pass++;
    #1;
    rst = 0;
    #1;
    n_total++;
    if (all_out !== '0) $display("FAIL midrst_async got=%h exp=0", all_out);
    else n_pass++;
    @(negedge clk);
    rst = 1; s_rvalid = 0; mdl_last = 1;
    #1;
    n_total++;
    if ({m0_arready, m1_arready, state_o, grant_o, s_arvalid} !== {2'b10, ST_IDLE, 2'b00, 1'b0})
      $display("FAIL midrst_restart got=%b exp=1000000", {m0_arready, m1_arready, state_o, grant_o, s_arvalid});
    else n_pass++;
    @(negedge clk);
    m0_arvalid = 0;
  endtask

  // Transaction-level model: pending requests per master, round-robin on ties,
  // every slave beat accepted by the owner must reach the owner unchanged.
  task automatic test_random(input int n_txn);
    bit pend[2];
    logic [W-1:0] paddr[2];
    logic [W-1:0] addr, got_d, exp_d;
    int win, stall, c, m;
    bit done, own_rdy, got_v;
    logic [2*W+6:0] obs_r, exp_r;
    apply_reset();
    pend[0] = 0; pend[1] = 0;
    for (int t = 0; t < n_txn; t++) begin
      for (int k = 0; k < 2; k++)
        if (!pend[k] && $urandom_range(0, 1) == 1) begin pend[k] = 1; paddr[k] = $urandom; end
      if (!pend[0] && !pend[1]) begin
        m = $urandom_range(0, 1); pend[m] = 1; paddr[m] = $urandom;
      end
      m0_arvalid = pend[0]; m0_araddr = paddr[0];
      m1_arvalid = pend[1]; m1_araddr = paddr[1];
      s_rvalid = $urandom_range(0, 1); s_rdata = $urandom;
      win = (pend[0] && pend[1]) ? 1 - mdl_last : (pend[1] ? 1 : 0);
      #1;
      n_total++;
      if ({m0_arready, m1_arready, grant_o, s_arvalid, s_rready, m0_rvalid, m1_rvalid} !==
          {(win == 0), (win == 1), 6'b0})
        $display("FAIL rnd_idle t=%0d got=%b exp_winner=%0d", t,
                 {m0_arready, m1_arready, grant_o, s_arvalid, s_rready, m0_rvalid, m1_rvalid}, win);
      else n_pass++;
      @(negedge clk);
      mdl_last = win; pend[win] = 0; addr = paddr[win];
      m0_arvalid = pend[0]; m1_arvalid = pend[1];
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        s_arready = (s == stall);
        s_rvalid = $urandom_range(0, 1); s_rdata = $urandom;
        m0_rready = $urandom_range(0, 1); m1_rready = $urandom_range(0, 1);
        #1;
        n_total++;
        if ({s_arvalid, s_araddr, m0_arready, m1_arready, s_rready, m0_rvalid, m1_rvalid, grant_o} !==
            {1'b1, addr, 5'b0, ((win == 1) ? 2'b10 : 2'b01)})
          $display("FAIL rnd_addr t=%0d s=%0d got=%h exp_addr=%h owner=%0d", t, s,
                   {s_arvalid, s_araddr, m0_arready, m1_arready, s_rready, m0_rvalid, m1_rvalid, grant_o}, addr, win);
        else n_pass++;
        @(negedge clk);
      end
      s_arready = 0;
      done = 0;
      c = 0;
      while (!done) begin
        s_rvalid = (c >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        s_rdata = $urandom; s_rresp = 2'($urandom_range(0, 3));
        own_rdy = (c >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        if (win == 1) begin m1_rready = own_rdy; m0_rready = $urandom_range(0, 1); end
        else          begin m0_rready = own_rdy; m1_rready = $urandom_range(0, 1); end
        exp_r = (win == 1) ? {1'b0, {W{1'b0}}, 2'b00, s_rvalid, s_rdata, s_rresp, own_rdy}
                           : {s_rvalid, s_rdata, s_rresp, 1'b0, {W{1'b0}}, 2'b00, own_rdy};
        obs_r = {m0_rvalid, m0_rdata, m0_rresp, m1_rvalid, m1_rdata, m1_rresp, s_rready};
        #1;
        obs_r = {m0_rvalid, m0_rdata, m0_rresp, m1_rvalid, m1_rdata, m1_rresp, s_rready};
        n_total++;
        if (obs_r !== exp_r)
          $display("FAIL rnd_route t=%0d c=%0d got=%h exp=%h", t, c, obs_r, exp_r);
        else n_pass++;
        if (s_rvalid && own_rdy) begin
          exp_q.push_back(s_rdata);
          got_v = (win == 1) ? m1_rvalid : m0_rvalid;
          got_d = (win == 1) ? m1_rdata : m0_rdata;
          exp_d = exp_q.pop_front();
          n_total++;
          if ({got_v, got_d} !== {1'b1, exp_d})
            $display("FAIL rnd_scoreboard t=%0d got_v=%b got=%h exp=%h", t, got_v, got_d, exp_d);
          else n_pass++;
          done = 1;
        end
        c++;
        @(negedge clk);
      end
      s_rvalid = 0; m0_rready = 0; m1_rready = 0;
    end
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_pass = 0;
    n_total = 0;
    mdl_last = 1;
    rst = 0;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_addr_stall();
    test_rdata_backpressure();
    test_back_to_back();
    test_rvalid_ignored();
    test_reset_mid_data();
    test_random(60);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_23060208_rd_arbiter.md
YSYX_23060208_RD_ARBITER -- requirements
Module: ysyx_23060208_rd_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, address/data width of all channels.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous active-low reset (0 = reset).
REQ-005 m0_araddr/m0_arvalid/m0_arready  in/in/out  DATA_WIDTH/1/1  IFU read-address channel (master 0).
REQ-006 m0_rdata/m0_rresp/m0_rvalid/m0_rready  out/out/out/in  DATA_WIDTH/2/1/1  IFU read-data channel.
REQ-007 m1_araddr/m1_arvalid/m1_arready  in/in/out  DATA_WIDTH/1/1  LSU read-address channel (master 1).
REQ-008 m1_rdata/m1_rresp/m1_rvalid/m1_rready  out/out/out/in  DATA_WIDTH/2/1/1  LSU read-data channel.
REQ-009 s_araddr/s_arvalid/s_arready  out/out/in  DATA_WIDTH/1/1  shared slave read-address channel.
REQ-010 s_rdata/s_rresp/s_rvalid/s_rready  in/in/in/out  DATA_WIDTH/2/1/1  shared slave read-data channel.
REQ-011 grant_o  out  2  one-hot owner of current transaction (bit0 IFU, bit1 LSU), 2'b00 when idle.

Function
REQ-012 FSM states SHALL be IDLE, ADDR, DATA; exactly one read transaction in flight.
REQ-013 IDLE: if exactly one mX_arvalid=1, that master wins; if both, the master not granted last wins (round-robin).
REQ-014 IDLE: winner's mX_arready SHALL be driven 1 combinationally that cycle; loser's arready 0; araddr latched; next state ADDR.
REQ-015 IDLE with no arvalid: all arready 0, state held.
REQ-016 last_grant register SHALL update only on an IDLE->ADDR transition.
REQ-017 ADDR: s_arvalid=1, s_araddr=latched address, stable until s_arready=1; on s_arvalid&s_arready -> DATA.
REQ-018 DATA: s_rdata/s_rresp/s_rvalid routed to owner's mX_r*; s_rready = owner's mX_rready; non-owner rvalid=0, rdata=0, rresp=0.
REQ-019 DATA: on s_rvalid&s_rready -> IDLE; grant_o returns to 2'b00 in IDLE.
REQ-020 mX_arready SHALL be 0 in ADDR and DATA; requests arriving then wait (arvalid held by master per AXI).
REQ-021 s_rready SHALL be 0 outside DATA; s_rvalid asserted in IDLE/ADDR SHALL be ignored.
REQ-022 s_rresp SHALL pass through unmodified; no error generation.
REQ-023 Latency: master AR handshake at cycle t -> s_arvalid at t+1; with s_arready=1 at t+1, DATA at t+2; min 3 cycles per transaction incl. IDLE.
REQ-024 Back-to-back: after DATA->IDLE, new grant SHALL be possible in the very next cycle (IDLE).
REQ-025 grant_o SHALL equal one-hot owner in ADDR and DATA.

Reset
REQ-026 rst=0 SHALL asynchronously force state IDLE, last_grant=LSU (so IFU wins first tie), latched address 0.
REQ-027 During reset all outputs SHALL be 0: m*_arready, m*_rvalid, m*_rdata, m*_rresp, s_arvalid, s_araddr, s_rready, grant_o.
REQ-028 Reset mid-ADDR or mid-DATA SHALL abandon the transaction; after release arbiter restarts from IDLE without replay.

Verification
REQ-029 Reset release, m0_arvalid=1 addr 0x80000000 only -> m0_arready=1 same cycle, s_arvalid=1 s_araddr=0x80000000 next cycle, grant_o=2'b01.
REQ-030 Both arvalid at first IDLE after reset -> IFU granted; on its completion with both still asserting, LSU granted next; then IFU again (strict alternation).
REQ-031 Slave holds s_arready=0 for 5 cycles in ADDR -> s_arvalid and s_araddr stable all 5 cycles, m*_arready=0 throughout.
REQ-032 LSU owner, s_rvalid=1 rdata=0xDEADBEEF rresp=2'b10, m1_rready=0 for 3 cycles -> m1_rvalid=1 data held, m0_rvalid=0, state DATA until m1_rready=1, then IDLE.
REQ-033 s_rvalid pulsed high while in ADDR -> s_rready=0, no master rvalid, no state change.
REQ-034 rst=0 asserted mid-DATA -> all outputs 0 immediately (async), IDLE after release, pending m0_arvalid granted in first post-reset cycle.
